// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Definitions shared by the fetch front end and the control decoder of the
// single-cycle RISC-V core:
//   - fetch_state_e : states of the instruction fetch FSM
//   - NOP_INSTR     : canonical NOP (addi x0,x0,0)
//   - OPC_*         : opcode[6:2] field values used by the control decoder
//   - helpers       : instruction-length and PC-alignment predicates
// -----------------------------------------------------------------------------
package rv_pkg;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [4:0] OPC_RTYPE  = 5'b01100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_ITYPE  = 5'b00100;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  // A 32-bit RISC-V encoding always has its two low bits set.
  function automatic logic is_not_32bit(input logic [31:0] word);
    return (word[1:0] != 2'b11);
  endfunction

  // Instruction addresses must be word aligned (no compressed support).
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the two handshakes of the fetch front end:
//   - instruction memory : imem_req/imem_addr/imem_ready (request channel),
//                          imem_rvalid/imem_rdata (response channel)
//   - decode stage       : instr/instr_pc/instr_valid/instr_ready, plus the
//                          illegal_instr flag qualified by instr_valid
// master : the fetch unit; slave : memory + decode side.
// -----------------------------------------------------------------------------
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        illegal_instr;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, illegal_instr,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, illegal_instr,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch front end of the single-cycle RISC-V core. Owns the PC, issues one
// outstanding word request at a time to instruction memory and holds each
// fetched word (with its PC) for decode until it is consumed.
// Ports:
//   clk            : system clock, rising edge
//   rst            : synchronous, active-high reset
//   bus            : instr_fetch_if.master (imem request/response, decode
//                    handshake, illegal_instr)
//   redirect_valid : branch/jump target valid, highest priority event
//   redirect_pc    : new PC
//   misalign_fault : sticky, set by a redirect to a non-word-aligned PC;
//                    the unit halts until rst
// -----------------------------------------------------------------------------
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        bus,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 misalign_fault
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  instr_r, instr_nxt_s;
  logic [31:0]  instr_pc_r, instr_pc_nxt_s;
  logic         instr_valid_r, instr_valid_nxt_s;
  logic         misalign_r, misalign_nxt_s;

  // Next-state / datapath update; redirect outranks every other event.
  always_comb begin
    state_nxt_s       = state_r;
    pc_nxt_s          = pc_r;
    instr_nxt_s       = instr_r;
    instr_pc_nxt_s    = instr_pc_r;
    instr_valid_nxt_s = instr_valid_r;
    misalign_nxt_s    = misalign_r;

    if (state_r == ST_HALT) begin
      // Only rst leaves HALT; redirects and responses are ignored.
      instr_valid_nxt_s = 1'b0;
      instr_nxt_s       = NOP_INSTR;
    end else if (redirect_valid) begin
      pc_nxt_s          = redirect_pc;
      instr_valid_nxt_s = 1'b0;
      instr_nxt_s       = NOP_INSTR;
      if (is_misaligned(redirect_pc)) begin
        misalign_nxt_s = 1'b1;
        state_nxt_s    = ST_HALT;
      end else begin
        case (state_r)
          // An accepted request still owes a response that must be dropped.
          ST_REQ:   state_nxt_s = bus.imem_ready  ? ST_DRAIN : ST_REQ;
          ST_WAIT:  state_nxt_s = bus.imem_rvalid ? ST_REQ   : ST_DRAIN;
          ST_HOLD:  state_nxt_s = ST_REQ;
          ST_DRAIN: state_nxt_s = bus.imem_rvalid ? ST_REQ   : ST_DRAIN;
          default:  state_nxt_s = ST_HALT;
        endcase
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          if (bus.imem_ready) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            instr_nxt_s       = bus.imem_rdata;
            instr_pc_nxt_s    = pc_r;
            instr_valid_nxt_s = 1'b1;
            pc_nxt_s          = pc_r + 32'd4;
            state_nxt_s       = ST_HOLD;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_nxt_s = 1'b0;
            instr_nxt_s       = NOP_INSTR;
            state_nxt_s       = ST_REQ;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          // The stale response is swallowed here, never loaded into instr.
          if (bus.imem_rvalid) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: state_nxt_s = ST_HALT;
      endcase
    end
  end

  // State, PC and decode-facing registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_REQ;
      pc_r          <= RESET_PC;
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      instr_r       <= instr_nxt_s;
      instr_pc_r    <= instr_pc_nxt_s;
      instr_valid_r <= instr_valid_nxt_s;
      misalign_r    <= misalign_nxt_s;
    end
  end

  // Request is a decode of the state register; masked while rst is high so
  // nothing is issued during the reset cycle.
  assign bus.imem_req      = (state_r == ST_REQ) && !rst;
  assign bus.imem_addr     = pc_r;
  assign bus.instr         = instr_r;
  assign bus.instr_pc      = instr_pc_r;
  assign bus.instr_valid   = instr_valid_r;
  assign bus.illegal_instr = is_not_32bit(instr_r);
  assign misalign_fault    = misalign_r;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch: memory and decode handshakes are driven
// step by step; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_if ifc ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (ifc.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.imem_ready   = 1'b0;
    ifc.imem_rvalid  = 1'b0;
    ifc.imem_rdata   = 32'h0000_0000;
    ifc.instr_ready  = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0000_0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();

    // ---- reset state (rst still high) ----
    chk("rst_imem_req",    ifc.imem_req,      32'd0);
    chk("rst_imem_addr",   ifc.imem_addr,     32'h0000_0000);
    chk("rst_instr",       ifc.instr,         32'h0000_0013);
    chk("rst_instr_pc",    ifc.instr_pc,      32'h0000_0000);
    chk("rst_instr_valid", ifc.instr_valid,   32'd0);
    chk("rst_misalign",    misalign_fault,    32'd0);

    // ---- zero-wait fetch of two instructions ----
    rst = 1'b0;
    #1;
    chk("t1_req0",  ifc.imem_req,  32'd1);
    chk("t1_addr0", ifc.imem_addr, 32'h0000_0000);
    ifc.imem_ready = 1'b1;
    step();                                   // -> WAIT
    ifc.imem_ready = 1'b0;
    chk("t1_wait_req", ifc.imem_req, 32'd0);
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0050_0093;
    step();                                   // -> HOLD
    ifc.imem_rvalid = 1'b0;
    chk("t1_valid0",   ifc.instr_valid,   32'd1);
    chk("t1_instr0",   ifc.instr,         32'h0050_0093);
    chk("t1_pc0",      ifc.instr_pc,      32'h0000_0000);
    chk("t1_illegal0", ifc.illegal_instr, 32'd0);
    ifc.instr_ready = 1'b1;
    step();                                   // -> REQ
    chk("t1_consumed", ifc.instr_valid, 32'd0);
    chk("t1_nop",      ifc.instr,       32'h0000_0013);
    chk("t1_req1",     ifc.imem_req,    32'd1);
    chk("t1_addr1",    ifc.imem_addr,   32'h0000_0004);
    ifc.imem_ready = 1'b1;
    step();                                   // -> WAIT
    ifc.imem_ready  = 1'b0;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h00A0_0113;
    step();                                   // -> HOLD
    ifc.imem_rvalid = 1'b0;
    chk("t1_valid1", ifc.instr_valid, 32'd1);
    chk("t1_instr1", ifc.instr,       32'h00A0_0113);
    chk("t1_pc1",    ifc.instr_pc,    32'h0000_0004);
    step();                                   // consumed -> REQ
    chk("t1_addr2",  ifc.imem_addr,   32'h0000_0008);
    chk("t1_req2",   ifc.imem_req,    32'd1);

    // ---- memory stalls in REQ ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_held",  ifc.imem_req,    32'd1);
      chk("t2_addr_held", ifc.imem_addr,   32'h0000_0000);
      chk("t2_no_valid",  ifc.instr_valid, 32'd0);
    end
    ifc.imem_ready = 1'b1;
    step();                                   // -> WAIT
    ifc.imem_ready  = 1'b0;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0050_0093;
    step();                                   // -> HOLD
    ifc.imem_rvalid = 1'b0;

    // ---- decode stalls in HOLD ----
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_instr_held", ifc.instr,       32'h0050_0093);
      chk("t3_pc_held",    ifc.instr_pc,    32'h0000_0000);
      chk("t3_valid_held", ifc.instr_valid, 32'd1);
      chk("t3_no_req",     ifc.imem_req,    32'd0);
    end
    ifc.instr_ready = 1'b1;
    step();                                   // -> REQ, pc=4
    ifc.instr_ready = 1'b0;
    chk("t3_addr_next", ifc.imem_addr, 32'h0000_0004);

    // ---- redirect in WAIT, stale response drained ----
    ifc.imem_ready = 1'b1;
    step();                                   // -> WAIT
    ifc.imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();                                   // -> DRAIN
    redirect_valid = 1'b0;
    chk("t4_drain_req",   ifc.imem_req,    32'd0);
    chk("t4_drain_valid", ifc.instr_valid, 32'd0);
    step();                                   // still DRAIN
    chk("t4_drain_req2",  ifc.imem_req,    32'd0);
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'hDEAD_BEEF;
    step();                                   // stale dropped -> REQ
    ifc.imem_rvalid = 1'b0;
    chk("t4_no_stale",    ifc.instr,       32'h0000_0013);
    chk("t4_no_valid",    ifc.instr_valid, 32'd0);
    chk("t4_req",         ifc.imem_req,    32'd1);
    chk("t4_addr",        ifc.imem_addr,   32'h0000_0100);
    ifc.imem_ready = 1'b1;
    step();                                   // -> WAIT
    ifc.imem_ready  = 1'b0;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h00A0_0113;
    step();                                   // -> HOLD
    ifc.imem_rvalid = 1'b0;
    chk("t4_valid",  ifc.instr_valid, 32'd1);
    chk("t4_instr",  ifc.instr,       32'h00A0_0113);
    chk("t4_pc",     ifc.instr_pc,    32'h0000_0100);

    // ---- redirect in HOLD squashes even with instr_ready ----
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0200;
    ifc.instr_ready = 1'b1;
    step();                                   // -> REQ
    redirect_valid  = 1'b0;
    ifc.instr_ready = 1'b0;
    chk("t5_squash_valid", ifc.instr_valid, 32'd0);
    chk("t5_squash_instr", ifc.instr,       32'h0000_0013);
    chk("t5_addr",         ifc.imem_addr,   32'h0000_0200);
    chk("t5_req",          ifc.imem_req,    32'd1);

    // ---- redirect in REQ to last word, PC wrap, illegal encoding ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();                                   // stays REQ with new pc
    redirect_valid = 1'b0;
    chk("t6_addr_top", ifc.imem_addr, 32'hFFFF_FFFC);
    chk("t6_req_top",  ifc.imem_req,  32'd1);
    ifc.imem_ready = 1'b1;
    step();                                   // -> WAIT
    ifc.imem_ready  = 1'b0;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0000_0000;
    step();                                   // -> HOLD
    ifc.imem_rvalid = 1'b0;
    chk("t6_valid",   ifc.instr_valid,   32'd1);
    chk("t6_pc",      ifc.instr_pc,      32'hFFFF_FFFC);
    chk("t6_illegal", ifc.illegal_instr, 32'd1);
    chk("t6_instr",   ifc.instr,         32'h0000_0000);
    ifc.instr_ready = 1'b1;
    step();                                   // -> REQ
    ifc.instr_ready = 1'b0;
    chk("t6_wrap_addr", ifc.imem_addr, 32'h0000_0000);
    chk("t6_wrap_req",  ifc.imem_req,  32'd1);

    // ---- misaligned redirect halts until reset ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();                                   // -> HALT
    redirect_valid = 1'b0;
    chk("t7_fault", misalign_fault, 32'd1);
    chk("t7_req",   ifc.imem_req,   32'd0);
    ifc.imem_ready  = 1'b1;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0050_0093;
    ifc.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = (i == 1);
      redirect_pc    = 32'h0000_0200;
      step();
      chk("t7_halt_req",   ifc.imem_req,    32'd0);
      chk("t7_halt_valid", ifc.instr_valid, 32'd0);
      chk("t7_fault_stk",  misalign_fault,  32'd1);
    end
    idle_inputs();
    rst = 1'b1;
    step();
    chk("t7_rst_fault", misalign_fault, 32'd0);
    chk("t7_rst_req",   ifc.imem_req,   32'd0);
    rst = 1'b0;
    #1;
    chk("t7_post_req",  ifc.imem_req,   32'd1);
    chk("t7_post_addr", ifc.imem_addr,  32'h0000_0000);

    // ---- late response while in REQ after reset is dropped ----
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'hDEAD_BEEF;
    step();
    ifc.imem_rvalid = 1'b0;
    chk("t8_late_valid", ifc.instr_valid, 32'd0);
    chk("t8_late_instr", ifc.instr,       32'h0000_0013);
    chk("t8_late_req",   ifc.imem_req,    32'd1);
    chk("t8_late_addr",  ifc.imem_addr,   32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
